bmc_decoder: RTL and testbench
==============================

BMC_DECODER -- requirements
Module: bmc_decoder

Interface
REQ-001 Parameter SHORT_MIN, default 16: minimum edge interval in clk cycles accepted as a half-bit.
REQ-002 Parameter SHORT_MAX, default 35: maximum interval classed as short (half-bit).
REQ-003 Parameter LONG_MAX, default 60: maximum interval classed as long (full bit).
REQ-004 Parameter TIMEOUT, default 96: idle cycles without an edge that end a frame; TIMEOUT > LONG_MAX.
REQ-005 Parameter WORD_BITS, default 17: bits per assembled word.
REQ-006 clk_25MHz  input  1  system clock; all logic on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 envelop_wire  input  1  asynchronous envelope from the photodiode front-end; high = carrier present.
REQ-009 data_wire  input  1  asynchronous biphase-mark-coded data from the same receiver.
REQ-010 bit_out  output  1  decoded bit, valid only while bit_valid is high.
REQ-011 bit_valid  output  1  one-cycle pulse per decoded bit.
REQ-012 word_out  output  WORD_BITS  assembled word, first-received bit in MSB; held until the next word completes.
REQ-013 word_valid  output  1  one-cycle pulse when word_out is updated.
REQ-014 frame_active  output  1  high while the decoder is locked on a frame.
REQ-015 decode_error  output  1  one-cycle pulse on a timing violation.

Function
REQ-016 envelop_wire and data_wire shall each pass through a 2-flop synchronizer; an edge is a difference between the synchronizer output and its registered copy.
REQ-017 An 8-bit interval counter shall count cycles since the last edge, saturate at 255, and restart at 1 on each edge.
REQ-018 Classification at each edge: interval < SHORT_MIN = glitch; SHORT_MIN..SHORT_MAX = short; SHORT_MAX+1..LONG_MAX = long; > LONG_MAX = glitch.
REQ-019 FSM states: IDLE, SYNC, RUN, HALF.
REQ-020 IDLE: synchronized envelope high -> SYNC.
REQ-021 SYNC: first data edge -> RUN, assert frame_active; no bit is emitted for this edge.
REQ-022 RUN: long edge emits bit 0 and stays in RUN; short edge -> HALF, no bit emitted.
REQ-023 HALF: short edge emits bit 1 and returns to RUN; long edge is an error.
REQ-024 Glitch in RUN or HALF shall pulse decode_error, clear the bit count, and go to SYNC; the offending edge is not used as the timing reference.
REQ-025 Error in HALF (long edge) shall pulse decode_error, clear the bit count, and go to SYNC.
REQ-026 bit_valid/bit_out shall be registered and appear in the cycle after the completing edge is detected.
REQ-027 Bits shift into a WORD_BITS register MSB-first; bit counter 0..WORD_BITS-1.
REQ-028 On the WORD_BITS-th bit, word_out shall load the full word and word_valid shall pulse in the same cycle as that bit's bit_valid; the counter wraps to 0 and decoding continues.
REQ-029 In RUN or HALF, interval counter reaching TIMEOUT shall go to SYNC, drop frame_active, and discard the partial word without error.
REQ-030 Synchronized envelope low in any state shall go to IDLE within one cycle, drop frame_active, and discard the partial word; a bit completing in that same cycle is discarded.
REQ-031 word_out shall never change except on word_valid.

Reset
REQ-032 reset_n low shall immediately force the FSM to IDLE and clear the synchronizers, counters, shift register, and word_out (0); bit_out, bit_valid, word_valid, frame_active, and decode_error shall be 0.
REQ-033 Reset release shall take effect on the next clk edge; an asserted envelope is then seen after synchronizer latency.

Verification
REQ-034 Envelope high; data edges at intervals 48,24,24,48 (defaults) -> bits 0,1,0 in order, no decode_error.
REQ-035 Envelope high; 17 bits 0,1,1,1,0,0,1,0,1,1,1,1,0,1,0,0,1 at nominal timing (24/48) -> word_out=0x0E5E9 with a single word_valid coinciding with the 17th bit_valid.
REQ-036 Short edge (24) followed by long edge (48) -> decode_error pulse, FSM in SYNC, bit count 0; the next valid 17 bits still produce a correct word.
REQ-037 Edge interval 8 -> decode_error; no edge for 96 cycles mid-word -> frame_active falls, no word_valid, no error.
REQ-038 Envelope drops after bit 10 of a word -> FSM in IDLE, no word_valid; a full word after re-assertion decodes correctly.
REQ-039 reset_n asserted mid-word -> all outputs 0 asynchronously, word_out=0.

Source files
------------

// File: rtl/bmc_decoder.sv
// Biphase-mark-code receiver: synchronizes envelope and data, times data edges,
// decodes half/full-bit intervals into bits and assembles MSB-first words.
module bmc_decoder #(
    parameter int SHORT_MIN = 16,
    parameter int SHORT_MAX = 35,
    parameter int LONG_MAX  = 60,
    parameter int TIMEOUT   = 96,
    parameter int WORD_BITS = 17
) (
    input  logic                 clk_25MHz,
    input  logic                 reset_n,
    input  logic                 envelop_wire,
    input  logic                 data_wire,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [WORD_BITS-1:0] word_out,
    output logic                 word_valid,
    output logic                 frame_active,
    output logic                 decode_error
);
    localparam int CW = $clog2(WORD_BITS);
    localparam logic [7:0] SHORT_MIN_C = 8'(SHORT_MIN);
    localparam logic [7:0] SHORT_MAX_C = 8'(SHORT_MAX);
    localparam logic [7:0] LONG_MAX_C  = 8'(LONG_MAX);
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALF = 2'd3
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 env_meta_r, env_sync_r;
    logic                 data_meta_r, data_sync_r, data_prev_r;
    logic                 data_edge_s;
    logic [7:0]           cnt_r;
    logic                 is_short_s, is_long_s;
    logic                 emit_s, bit_s, err_s, clear_s, restart_s;
    logic [CW-1:0]        bit_cnt_r;
    logic [WORD_BITS-1:0] shift_r, word_nxt_s;

    // Two-flop synchronizers plus a delayed data copy for edge detection
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            env_meta_r  <= 1'b0;
            env_sync_r  <= 1'b0;
            data_meta_r <= 1'b0;
            data_sync_r <= 1'b0;
            data_prev_r <= 1'b0;
        end else begin
            env_meta_r  <= envelop_wire;
            env_sync_r  <= env_meta_r;
            data_meta_r <= data_wire;
            data_sync_r <= data_meta_r;
            data_prev_r <= data_sync_r;
        end
    end

    assign data_edge_s = data_sync_r ^ data_prev_r;
    assign is_short_s  = (cnt_r >= SHORT_MIN_C) && (cnt_r <= SHORT_MAX_C);
    assign is_long_s   = (cnt_r > SHORT_MAX_C) && (cnt_r <= LONG_MAX_C);
    assign word_nxt_s  = {shift_r[WORD_BITS-2:0], bit_s};

    // Interval counter: value at an edge equals cycles since the last reference edge
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 8'd0;
        end else if (restart_s) begin
            cnt_r <= 8'd1;
        end else if (cnt_r != 8'hFF) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; losing the envelope overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (!env_sync_r) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_SYNC;
                ST_SYNC: begin
                    if (data_edge_s) state_nxt_s = ST_RUN;
                    else             state_nxt_s = ST_SYNC;
                end
                ST_RUN: begin
                    if (data_edge_s) begin
                        if (is_long_s)       state_nxt_s = ST_RUN;
                        else if (is_short_s) state_nxt_s = ST_HALF;
                        else                 state_nxt_s = ST_SYNC;
                    end else if (cnt_r >= TIMEOUT_C) begin
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALF: begin
                    if (data_edge_s) begin
                        if (is_short_s) state_nxt_s = ST_RUN;
                        else            state_nxt_s = ST_SYNC;
                    end else if (cnt_r >= TIMEOUT_C) begin
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_HALF;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: bit emission, error, word discard and counter restart
    always_comb begin
        emit_s    = 1'b0;
        bit_s     = 1'b0;
        err_s     = 1'b0;
        clear_s   = 1'b0;
        restart_s = data_edge_s;
        if (!env_sync_r) begin
            clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (data_edge_s) begin
                        if (is_long_s) begin
                            emit_s = 1'b1;
                        end else if (is_short_s) begin
                            emit_s = 1'b0;
                        end else begin
                            err_s     = 1'b1;
                            clear_s   = 1'b1;
                            restart_s = 1'b0;
                        end
                    end else begin
                        clear_s = (cnt_r >= TIMEOUT_C);
                    end
                end
                ST_HALF: begin
                    if (data_edge_s) begin
                        if (is_short_s) begin
                            emit_s = 1'b1;
                            bit_s  = 1'b1;
                        end else if (is_long_s) begin
                            err_s   = 1'b1;
                            clear_s = 1'b1;
                        end else begin
                            err_s     = 1'b1;
                            clear_s   = 1'b1;
                            restart_s = 1'b0;
                        end
                    end else begin
                        clear_s = (cnt_r >= TIMEOUT_C);
                    end
                end
                ST_IDLE: clear_s = 1'b1;
                ST_SYNC: clear_s = 1'b0;
                default: clear_s = 1'b1;
            endcase
        end
    end

    // Word assembly and registered outputs
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            frame_active <= 1'b0;
            decode_error <= 1'b0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
        end else begin
            bit_valid    <= emit_s;
            bit_out      <= emit_s & bit_s;
            decode_error <= err_s;
            frame_active <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_HALF);
            word_valid   <= 1'b0;
            if (clear_s) begin
                bit_cnt_r <= '0;
                shift_r   <= '0;
            end else if (emit_s) begin
                shift_r <= word_nxt_s;
                if (bit_cnt_r == LAST_BIT) begin
                    word_out   <= word_nxt_s;
                    word_valid <= 1'b1;
                    bit_cnt_r  <= '0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
                shift_r   <= shift_r;
            end
        end
    end
endmodule

// File: tb/tb_bmc_decoder.sv
// Bench for bmc_decoder: table vectors, directed word/abort/reset sequences,
// and random BMC streams checked against an interval-level reference model.
module tb_bmc_decoder;
    localparam int SMIN = 16;
    localparam int SMAX = 35;
    localparam int LMAX = 60;
    localparam int TO   = 96;
    localparam int WB   = 17;
    localparam logic [WB-1:0] REF_WORD = 17'h0E5E9;

    logic          clk = 1'b0;
    logic          reset_n, env, data;
    logic          bit_out, bit_valid, word_valid, frame_active, decode_error;
    logic [WB-1:0] word_out;

    bmc_decoder dut (
        .clk_25MHz(clk), .reset_n(reset_n), .envelop_wire(env), .data_wire(data),
        .bit_out(bit_out), .bit_valid(bit_valid), .word_out(word_out),
        .word_valid(word_valid), .frame_active(frame_active), .decode_error(decode_error)
    );

    always #20 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    int            stim[$];
    logic          got_bits[$];
    logic [WB-1:0] got_words[$];
    int            got_err = 0;
    logic          exp_bits[$];
    logic [WB-1:0] exp_words[$];
    logic [WB-1:0] prev_word;

    typedef struct {
        int n;
        int iv[5];
        int nbits;
        int bits;
        int errs;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture output pulses and watch that word_out only moves with word_valid
    always @(negedge clk) begin
        if (bit_valid) got_bits.push_back(bit_out);
        if (word_valid) begin
            got_words.push_back(word_out);
            chk("word_valid_with_bit_valid", {31'd0, bit_valid}, 32'd1);
        end
        if (decode_error) got_err++;
        if (!reset_n) prev_word = word_out;
        else if (word_out !== prev_word) begin
            chk("word_out_changes_only_on_word_valid", {31'd0, word_valid}, 32'd1);
            prev_word = word_out;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_stim();
        foreach (stim[i]) begin
            repeat (stim[i]) @(posedge clk);
            #1 data = ~data;
        end
    endtask

    task automatic clear_mon();
        got_bits.delete();
        got_words.delete();
        got_err = 0;
    endtask

    task automatic add_bit(input logic b);
        if (b) begin
            stim.push_back(24);
            stim.push_back(24);
        end else begin
            stim.push_back(48);
        end
    endtask

    task automatic add_word(input logic [WB-1:0] w);
        for (int i = WB - 1; i >= 0; i--) add_bit(w[i]);
    endtask

    task automatic addv(input int n, input int a0, input int a1, input int a2,
                        input int a3, input int a4, input int nb, input int bv, input int ne);
        vec_t v;
        v.n = n; v.iv[0] = a0; v.iv[1] = a1; v.iv[2] = a2; v.iv[3] = a3; v.iv[4] = a4;
        v.nbits = nb; v.bits = bv; v.errs = ne;
        vq.push_back(v);
    endtask

    // Reference: walk absolute edge times; lock on first edge, then classify gaps
    task automatic model_run(output int nerr);
        int t, ref_t, d;
        bit locked, half;
        int nb;
        logic [WB-1:0] acc;
        exp_bits.delete(); exp_words.delete();
        nerr = 0; t = 0; ref_t = 0; d = 0; locked = 0; half = 0; nb = 0; acc = '0;
        foreach (stim[i]) begin
            t += stim[i];
            if (locked) begin
                d = t - ref_t;
                if (d > TO) locked = 0;
            end
            if (!locked) begin
                locked = 1; half = 0; nb = 0; ref_t = t;
                continue;
            end
            if (d < SMIN || d > LMAX || (half && d > SMAX)) begin
                nerr++; locked = 0; half = 0; nb = 0;
                continue;
            end
            ref_t = t;
            if (d > SMAX || half) begin
                logic b;
                b = half;
                half = 0;
                acc = {acc[WB-2:0], b};
                exp_bits.push_back(b);
                nb++;
                if (nb == WB) begin
                    exp_words.push_back(acc);
                    nb = 0;
                end
            end else begin
                half = 1;
            end
        end
    endtask

    function automatic int rnd_short();
        return int'($urandom_range(SMIN, SMAX));
    endfunction

    function automatic int rnd_long();
        return int'($urandom_range(SMAX + 1, LMAX));
    endfunction

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad[6] = '{5, 12, 62, 80, 96, 97};
        int nerr, act;
        reset_n = 1'b0; env = 1'b0; data = 1'b0;
        #5;
        chk("reset_outputs", {26'd0, bit_out, bit_valid, word_valid, frame_active, decode_error, |word_out}, 32'd0);
        settle(3);
        reset_n = 1'b1;
        settle(2);
        env = 1'b1;
        settle(10);

        // {n, intervals (first = lead-in to locking edge), nbits, bits MSB-first, errors}
        addv(5, 30, 48, 24, 24, 48, 3, 2, 0);
        addv(3, 30, 24, 48, 0, 0, 0, 0, 1);
        addv(2, 30, 8, 0, 0, 0, 0, 0, 1);
        addv(3, 30, 48, 70, 0, 0, 1, 0, 1);
        addv(5, 30, 16, 35, 36, 60, 3, 4, 0);
        addv(2, 30, 15, 0, 0, 0, 0, 0, 1);
        addv(3, 30, 48, 61, 0, 0, 1, 0, 1);
        addv(3, 30, 24, 8, 0, 0, 0, 0, 1);
        addv(4, 30, 48, 8, 40, 0, 1, 0, 1);
        addv(3, 30, 48, 96, 0, 0, 1, 0, 1);
        addv(4, 30, 48, 97, 48, 0, 2, 0, 0);
        foreach (vq[i]) begin
            stim.delete();
            for (int k = 0; k < vq[i].n; k++) stim.push_back(vq[i].iv[k]);
            clear_mon();
            send_stim();
            settle(130);
            act = 0;
            foreach (got_bits[j]) act = (act << 1) | int'(got_bits[j]);
            chk($sformatf("vec%0d_nbits", i), got_bits.size(), vq[i].nbits);
            chk($sformatf("vec%0d_bits", i), act, vq[i].bits);
            chk($sformatf("vec%0d_errors", i), got_err, vq[i].errs);
        end

        // Full nominal word
        stim.delete(); stim.push_back(30); add_word(REF_WORD);
        clear_mon(); send_stim(); settle(5);
        chk("word_frame_active", {31'd0, frame_active}, 32'd1);
        settle(125);
        chk("word_count", got_words.size(), 1);
        chk("word_value", word_out, REF_WORD);
        chk("word_errors", got_err, 0);

        // Short then long error, then a clean word
        stim.delete(); stim.push_back(30); stim.push_back(24); stim.push_back(48);
        stim.push_back(30); add_word(17'h1A5C3);
        clear_mon(); send_stim(); settle(130);
        chk("err_recover_errors", got_err, 1);
        chk("err_recover_count", got_words.size(), 1);
        chk("err_recover_word", word_out, 17'h1A5C3);

        // Timeout mid-word, then a clean word
        stim.delete(); stim.push_back(30);
        for (int i = 0; i < 5; i++) add_bit(1'(i));
        clear_mon(); send_stim(); settle(10);
        chk("timeout_active_before", {31'd0, frame_active}, 32'd1);
        settle(120);
        chk("timeout_active_after", {31'd0, frame_active}, 32'd0);
        chk("timeout_no_word", got_words.size(), 0);
        chk("timeout_no_error", got_err, 0);
        stim.delete(); stim.push_back(30); add_word(REF_WORD);
        clear_mon(); send_stim(); settle(130);
        chk("timeout_next_word", (got_words.size() == 1) ? got_words[0] : '1, REF_WORD);

        // Envelope drop after bit 10, then a clean word
        stim.delete(); stim.push_back(30);
        for (int i = 0; i < 10; i++) add_bit(1'(i >> 1));
        clear_mon(); send_stim(); settle(8);
        env = 1'b0;
        settle(6);
        chk("env_drop_active", {31'd0, frame_active}, 32'd0);
        settle(120);
        chk("env_drop_no_word", got_words.size(), 0);
        chk("env_drop_no_error", got_err, 0);
        env = 1'b1;
        settle(10);
        stim.delete(); stim.push_back(30); add_word(17'h15555);
        clear_mon(); send_stim(); settle(130);
        chk("env_restore_word", (got_words.size() == 1) ? got_words[0] : '1, 17'h15555);

        // Asynchronous reset mid-word
        stim.delete(); stim.push_back(30);
        for (int i = 0; i < 6; i++) add_bit(1'b0);
        clear_mon(); send_stim(); settle(5);
        chk("pre_reset_active", {31'd0, frame_active}, 32'd1);
        #10 reset_n = 1'b0; data = 1'b0;
        #1;
        chk("async_reset_word_out", word_out, 0);
        chk("async_reset_active", {31'd0, frame_active}, 32'd0);
        chk("async_reset_pulses", {29'd0, bit_out, bit_valid, word_valid} | {31'd0, decode_error}, 32'd0);
        settle(3);
        reset_n = 1'b1;
        settle(12);
        chk("reset_no_word", got_words.size(), 0);

        // Random streams against the reference model
        for (int p = 0; p < 5; p++) begin
            int nsym;
            stim.delete(); stim.push_back(30);
            nsym = int'($urandom_range(20, 60));
            for (int k = 0; k < nsym; k++) begin
                int r;
                r = int'($urandom_range(0, 24));
                if (r == 0) begin
                    stim.push_back(bad[$urandom_range(0, 5)]);
                end else if (r == 1) begin
                    stim.push_back(rnd_short());
                    stim.push_back(rnd_long());
                end else if ($urandom_range(0, 1) == 1) begin
                    stim.push_back(rnd_short());
                    stim.push_back(rnd_short());
                end else begin
                    stim.push_back(rnd_long());
                end
            end
            clear_mon(); send_stim(); settle(130);
            model_run(nerr);
            chk($sformatf("rand%0d_nbits", p), got_bits.size(), exp_bits.size());
            for (int j = 0; j < exp_bits.size() && j < got_bits.size(); j++)
                chk($sformatf("rand%0d_bit%0d", p, j), {31'd0, got_bits[j]}, {31'd0, exp_bits[j]});
            chk($sformatf("rand%0d_nwords", p), got_words.size(), exp_words.size());
            for (int j = 0; j < exp_words.size() && j < got_words.size(); j++)
                chk($sformatf("rand%0d_word%0d", p, j), got_words[j], exp_words[j]);
            chk($sformatf("rand%0d_errors", p), got_err, nerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
